// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter for the nibble write port of the 4-in/8-out FIFO.
// It also issues read-side pops, which take priority over writes in any cycle.
module fifo_wr_arbiter #(
    parameter int DW      = 4,
    parameter int BURST   = 2,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [DW-1:0] data0,
    output logic          ack0,
    input  logic          req1,
    input  logic [DW-1:0] data1,
    output logic          ack1,
    input  logic          fifo_in_en,
    input  logic          fifo_out_v,
    input  logic          sink_rdy,
    output logic          fifo_in_v,
    output logic [DW-1:0] fifo_data,
    output logic          fifo_out_en,
    output logic [1:0]    grant,
    output logic          err
);

    localparam int BW = $clog2(BURST + 1);
    localparam int IW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic          last_owner, last_owner_nx;
    logic [BW-1:0] burst_cnt, burst_cnt_nx;
    logic [IW-1:0] idle_cnt, idle_cnt_nx;
    logic          err_nx;
    logic [1:0]    grant_nx;
    logic          pop;
    logic          owner_req;
    logic          owner;

    assign pop         = fifo_out_v & sink_rdy;
    assign fifo_out_en = pop;
    assign owner       = (state == OWN1);
    assign owner_req   = ((state == OWN0) & req0) | ((state == OWN1) & req1);
    assign fifo_in_v   = owner_req & fifo_in_en & ~pop;
    assign ack0        = fifo_in_v & grant[0];
    assign ack1        = fifo_in_v & grant[1];
    assign fifo_data   = owner ? data1 : data0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 2'b00;
            err        <= 1'b0;
            last_owner <= 1'b1;
            burst_cnt  <= '0;
            idle_cnt   <= '0;
        end else begin
            state      <= state_nx;
            grant      <= grant_nx;
            err        <= err_nx;
            last_owner <= last_owner_nx;
            burst_cnt  <= burst_cnt_nx;
            idle_cnt   <= idle_cnt_nx;
        end
    end

    // Only an owner that is free to write but has nothing to offer ages toward the timeout.
    always_comb begin
        state_nx      = state;
        last_owner_nx = last_owner;
        burst_cnt_nx  = burst_cnt;
        idle_cnt_nx   = idle_cnt;
        err_nx        = 1'b0;
        case (state)
            IDLE: begin
                if (req0 && req1)
                    state_nx = last_owner ? OWN0 : OWN1;
                else if (req0)
                    state_nx = OWN0;
                else if (req1)
                    state_nx = OWN1;
            end
            OWN0, OWN1: begin
                if (fifo_in_v) begin
                    idle_cnt_nx = '0;
                    if (burst_cnt == BW'(BURST - 1)) begin
                        state_nx      = IDLE;
                        last_owner_nx = owner;
                        burst_cnt_nx  = '0;
                    end else begin
                        burst_cnt_nx = burst_cnt + BW'(1);
                    end
                end else if (fifo_in_en && !pop) begin
                    if (idle_cnt == IW'(TIMEOUT - 1)) begin
                        state_nx      = IDLE;
                        last_owner_nx = owner;
                        burst_cnt_nx  = '0;
                        idle_cnt_nx   = '0;
                        err_nx        = 1'b1;
                    end else begin
                        idle_cnt_nx = idle_cnt + IW'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        grant_nx = {state_nx == OWN1, state_nx == OWN0};
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural owner/count model.
module tb_fifo_wr_arbiter;

    localparam int DW      = 4;
    localparam int BURST   = 2;
    localparam int TIMEOUT = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [DW-1:0] data0 = '0, data1 = '0;
    logic          fifo_in_en = 1'b1, fifo_out_v = 1'b0, sink_rdy = 1'b0;
    logic          ack0, ack1, fifo_in_v, fifo_out_en, err;
    logic [DW-1:0] fifo_data;
    logic [1:0]    grant;

    int assertCount = 0;
    int failCount   = 0;

    // Model: owner -1 = nobody, nibbles written in the current burst, idle cycles, last owner.
    int mOwner = -1;
    int mLast  = 1;
    int mNib   = 0;
    int mIdle  = 0;
    bit mErr   = 1'b0;

    fifo_wr_arbiter #(.DW(DW), .BURST(BURST), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .ack0(ack0),
        .req1(req1), .data1(data1), .ack1(ack1),
        .fifo_in_en(fifo_in_en), .fifo_out_v(fifo_out_v), .sink_rdy(sink_rdy),
        .fifo_in_v(fifo_in_v), .fifo_data(fifo_data), .fifo_out_en(fifo_out_en),
        .grant(grant), .err(err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic [DW-1:0] d0, input logic r1,
                                 input logic [DW-1:0] d1, input logic en, input logic ov,
                                 input logic rdy);
        req0 = r0; data0 = d0; req1 = r1; data1 = d1;
        fifo_in_en = en; fifo_out_v = ov; sink_rdy = rdy;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic resetPulse();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
    endtask

    function automatic bit modelWrite();
        bit ownerReq;
        ownerReq = (mOwner == 0 && req0) || (mOwner == 1 && req1);
        return ownerReq && fifo_in_en && !(fifo_out_v && sink_rdy);
    endfunction

    // Behavioural model advance
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mOwner = -1; mLast = 1; mNib = 0; mIdle = 0; mErr = 1'b0;
        end else begin
            mErr = 1'b0;
            if (mOwner < 0) begin
                if (req0 && req1)      mOwner = 1 - mLast;
                else if (req0)         mOwner = 0;
                else if (req1)         mOwner = 1;
            end else if (modelWrite()) begin
                mNib++;
                mIdle = 0;
                if (mNib == BURST) begin
                    mLast = mOwner; mOwner = -1; mNib = 0;
                end
            end else if (fifo_in_en && !(fifo_out_v && sink_rdy)) begin
                mIdle++;
                if (mIdle == TIMEOUT) begin
                    mErr = 1'b1; mLast = mOwner; mOwner = -1; mNib = 0; mIdle = 0;
                end
            end
        end
    end

    // Compare process
    always @(negedge clk) begin
        bit wr;
        logic [1:0] expGrant;
        wr = modelWrite();
        expGrant = (mOwner == 0) ? 2'b01 : (mOwner == 1) ? 2'b10 : 2'b00;
        checkOutput("grant", grant, expGrant);
        checkOutput("err", err, mErr);
        checkOutput("fifo_out_en", fifo_out_en, fifo_out_v && sink_rdy);
        checkOutput("fifo_in_v", fifo_in_v, wr);
        checkOutput("ack0", ack0, wr && mOwner == 0);
        checkOutput("ack1", ack1, wr && mOwner == 1);
        checkOutput("fifo_data", fifo_data, (mOwner == 1) ? data1 : data0);
    end

    initial begin
        logic [1:0] seq [8];
        seq = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01};

        nextCycle();
        nextCycle();
        checkOutput("reset_grant", grant, 2'b00);
        checkOutput("reset_err", err, 1'b0);
        checkOutput("reset_data", fifo_data, data0);
        rst = 1'b0;

        // Single producer burst A,B
        applyStimulus(1'b1, 4'hA, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        nextCycle(); #1;
        checkOutput("t1_grant", grant, 2'b01);
        checkOutput("t1_ack_a", ack0, 1'b1);
        checkOutput("t1_data_a", fifo_data, 4'hA);
        nextCycle();
        data0 = 4'hB; #1;
        checkOutput("t1_ack_b", ack0, 1'b1);
        checkOutput("t1_data_b", fifo_data, 4'hB);
        nextCycle();
        req0 = 1'b0; #1;
        checkOutput("t1_release", grant, 2'b00);
        checkOutput("t1_no_ack", ack0, 1'b0);

        // Both request from reset: alternating bursts with an idle gap
        resetPulse();
        applyStimulus(1'b1, 4'h3, 1'b1, 4'hC, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            nextCycle(); #1;
            checkOutput("t2_grant_seq", grant, seq[i]);
        end

        // Pop preempts a write during OWN1
        resetPulse();
        applyStimulus(1'b0, '0, 1'b1, 4'h5, 1'b1, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b1, 4'h5, 1'b1, 1'b1, 1'b1); #1;
        checkOutput("t3_pop", fifo_out_en, 1'b1);
        checkOutput("t3_in_v", fifo_in_v, 1'b0);
        checkOutput("t3_ack1", ack1, 1'b0);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b1, 4'h6, 1'b1, 1'b0, 1'b0); #1;
        checkOutput("t3_resume", ack1, 1'b1);
        checkOutput("t3_grant", grant, 2'b10);

        // Owner abandons mid-burst: timeout after TIMEOUT idle cycles
        resetPulse();
        applyStimulus(1'b1, 4'h9, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        nextCycle();
        nextCycle();
        applyStimulus(1'b0, 4'h9, 1'b1, 4'h4, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < TIMEOUT; i++) begin
            #1;
            checkOutput("t4_hold_grant", grant, 2'b01);
            checkOutput("t4_no_err", err, 1'b0);
            nextCycle();
        end
        #1;
        checkOutput("t4_err", err, 1'b1);
        checkOutput("t4_released", grant, 2'b00);
        nextCycle(); #1;
        checkOutput("t4_next_grant", grant, 2'b10);
        checkOutput("t4_err_pulse", err, 1'b0);

        // FIFO full stalls without timing out
        resetPulse();
        applyStimulus(1'b1, 4'h7, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        nextCycle();
        nextCycle();
        fifo_in_en = 1'b0;
        for (int i = 0; i < 30; i++) begin
            #1;
            checkOutput("t5_no_ack", ack0, 1'b0);
            checkOutput("t5_no_err", err, 1'b0);
            checkOutput("t5_grant", grant, 2'b01);
            nextCycle();
        end
        fifo_in_en = 1'b1; #1;
        checkOutput("t5_resume", ack0, 1'b1);

        // Asynchronous reset between edges
        resetPulse();
        applyStimulus(1'b1, 4'h2, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        nextCycle();
        nextCycle();
        #1 rst = 1'b1;
        #1;
        checkOutput("t6_grant", grant, 2'b00);
        checkOutput("t6_err", err, 1'b0);
        checkOutput("t6_ack", ack0, 1'b0);
        #1 rst = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            nextCycle();
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                #1 rst = 1'b0;
            end
            applyStimulus($urandom_range(0, 9) < 7, DW'($urandom), $urandom_range(0, 9) < 6,
                          DW'($urandom), $urandom_range(0, 9) < 8,
                          $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 5);
        end
        nextCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
